up_tpl_adc_pn_stats: RTL and testbench

- Per-channel PN-monitor statistics register block for the JESD204 TPL ADC.
- Counts PN error cycles per channel with saturating counters, tracks live/sticky OOS and counter overflow, and supports an atomic snapshot of all counters.
- Raises a maskable interrupt.
- Sits on the internal up bus beside up_adc_common/up_adc_channel; rdata/rack/wack are OR-combined by the parent regmap.
- Inputs are already in the up_clk domain.

---
 rtl/up_tpl_pn_stats_pkg.sv | 33 +++
 rtl/up_tpl_pn_counter.sv | 107 ++++++++++
 rtl/up_tpl_adc_pn_stats.sv | 175 +++++++++++++++++
 tb/tb_up_tpl_adc_pn_stats.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_tpl_pn_stats_pkg.sv
// Shared constants for the JESD204 TPL ADC PN-monitor statistics block:
// register offsets inside the 64-word window, CONTROL bit positions,
// the CAPS version word and the post-OOS holdoff length.
// Optional feature macro: UP_TPL_PN_STATS_OOS_GATE_EN (see up_tpl_pn_counter).
package up_tpl_pn_stats_pkg;

    // Word offsets inside the block window
    localparam logic [5:0] REG_CAPS        = 6'h00;
    localparam logic [5:0] REG_CONTROL     = 6'h01;
    localparam logic [5:0] REG_OOS_LIVE    = 6'h02;
    localparam logic [5:0] REG_OOS_STICKY  = 6'h03;
    localparam logic [5:0] REG_OVF_STICKY  = 6'h04;
    localparam logic [5:0] REG_IRQ_MASK    = 6'h05;
    localparam logic [5:0] REG_SHADOW_BASE = 6'h20;

    // CONTROL register bit positions
    localparam int CTRL_SNAPSHOT_BIT = 0;
    localparam int CTRL_CLEAR_BIT    = 1;
    localparam int CTRL_FREEZE_BIT   = 2;

    // Layout version reported in CAPS[15:0]
    localparam logic [15:0] CAPS_VERSION = 16'h0001;

    // Cycles of counting inhibit after OOS falls (gate feature only)
    localparam int unsigned HOLDOFF_LEN    = 16;
    localparam logic [3:0]  HOLDOFF_RELOAD = 4'(HOLDOFF_LEN - 1);

    // True when a window offset addresses the shadow-count region
    function automatic logic is_shadow_offset(input logic [5:0] off);
        return (off[5] == 1'b1);
    endfunction

endpackage

// File: rtl/up_tpl_pn_counter.sv
// Per-channel PN error counter: saturating live count, snapshot shadow,
// overflow pulse toward the top-level sticky register.
// With UP_TPL_PN_STATS_OOS_GATE_EN defined, counting is inhibited while the
// channel is out of sync and for HOLDOFF_LEN cycles after OOS falls.
module up_tpl_pn_counter
    import up_tpl_pn_stats_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pn_err,
    input  logic                 count_en,
`ifdef UP_TPL_PN_STATS_OOS_GATE_EN
    input  logic                 pn_oos,
    input  logic                 pn_oos_live,
`endif
    input  logic                 clear,
    input  logic                 snapshot,
    output logic [CNT_WIDTH-1:0] shadow,
    output logic                 ovf_set
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] shadow_q;
    logic [CNT_WIDTH-1:0] shadow_d;
    logic                 inhibit_s;
    logic                 inc_s;
    logic                 ovf_s;

`ifdef UP_TPL_PN_STATS_OOS_GATE_EN
    logic [3:0] holdoff_q;
    logic [3:0] holdoff_d;

    // Holdoff reloads while the registered OOS is high, then drains to zero;
    // the raw input closes the one-cycle gap before OOS_LIVE catches up
    always_comb begin
        holdoff_d = holdoff_q;
        if (pn_oos_live) begin
            holdoff_d = HOLDOFF_RELOAD;
        end else if (holdoff_q != 4'd0) begin
            holdoff_d = holdoff_q - 4'd1;
        end else begin
            holdoff_d = 4'd0;
        end
        inhibit_s = pn_oos | pn_oos_live | (holdoff_q != 4'd0);
    end

    // Holdoff counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff_q <= 4'd0;
        end else begin
            holdoff_q <= holdoff_d;
        end
    end
`else
    assign inhibit_s = 1'b0;
`endif

    // Next count: clear beats increment, saturate at all-ones and flag overflow;
    // the shadow captures the pre-clear, pre-increment count
    always_comb begin
        inc_s = pn_err & count_en & ~inhibit_s;
        cnt_d = cnt_q;
        ovf_s = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (inc_s) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
                ovf_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (snapshot) begin
            shadow_d = cnt_q;
        end else if (clear) begin
            shadow_d = '0;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Live counter and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow  = shadow_q;
    assign ovf_set = ovf_s;

endmodule

// File: rtl/up_tpl_adc_pn_stats.sv
// PN-monitor statistics register block for the JESD204 TPL ADC.
// Bus decode on the internal up bus, CONTROL/IRQ_MASK registers, OOS edge
// detection, OOS/overflow stickies, maskable interrupt, and one
// up_tpl_pn_counter per channel. rdata/rack/wack are zero unless this
// window is hit so the parent regmap can OR them together.
// Optional feature macro: UP_TPL_PN_STATS_OOS_GATE_EN (OOS counting gate).
module up_tpl_adc_pn_stats
    import up_tpl_pn_stats_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE    = 8'h03,
    parameter int         NUM_CHANNELS = 8,
    parameter int         CNT_WIDTH    = 24
) (
    input  logic                    up_clk,
    input  logic                    up_rstn,
    input  logic [NUM_CHANNELS-1:0] up_pn_err,
    input  logic [NUM_CHANNELS-1:0] up_pn_oos,
    input  logic                    up_wreq,
    input  logic [13:0]             up_waddr,
    input  logic [31:0]             up_wdata,
    output logic                    up_wack,
    input  logic                    up_rreq,
    input  logic [13:0]             up_raddr,
    output logic [31:0]             up_rdata,
    output logic                    up_rack,
    output logic                    up_pn_irq
);

    // Writable IRQ_MASK bits: one OOS enable per channel plus global overflow enable
    localparam logic [31:0] IRQ_MASK_WR = (NUM_CHANNELS >= 32) ? 32'hFFFF_FFFF :
        (((32'h1 << NUM_CHANNELS) - 32'h1) | 32'h8000_0000);

    logic                    w_hit_s;
    logic                    r_hit_s;
    logic [5:0]              w_off_s;
    logic [5:0]              r_off_s;
    logic                    ctrl_wr_s;
    logic                    snapshot_s;
    logic                    clear_s;
    logic                    count_en_s;
    logic [NUM_CHANNELS-1:0] oos_w1c_s;
    logic [NUM_CHANNELS-1:0] ovf_w1c_s;
    logic [NUM_CHANNELS-1:0] oos_edge_s;
    logic [NUM_CHANNELS-1:0] ovf_set_s;
    logic [31:0]             rd_data_s;
    logic [CNT_WIDTH-1:0]    shadow_s [NUM_CHANNELS];

    logic                    freeze_q,     freeze_d;
    logic [31:0]             irq_mask_q,   irq_mask_d;
    logic [NUM_CHANNELS-1:0] oos_live_q,   oos_live_d;
    logic [NUM_CHANNELS-1:0] oos_prev_q,   oos_prev_d;
    logic [NUM_CHANNELS-1:0] oos_sticky_q, oos_sticky_d;
    logic [NUM_CHANNELS-1:0] ovf_sticky_q, ovf_sticky_d;
    logic                    irq_q,        irq_d;
    logic                    wack_q,       wack_d;
    logic                    rack_q,       rack_d;
    logic [31:0]             rdata_q,      rdata_d;

    assign w_hit_s    = up_wreq & (up_waddr[13:6] == ADDR_BASE);
    assign r_hit_s    = up_rreq & (up_raddr[13:6] == ADDR_BASE);
    assign w_off_s    = up_waddr[5:0];
    assign r_off_s    = up_raddr[5:0];
    assign ctrl_wr_s  = w_hit_s & (w_off_s == REG_CONTROL);
    assign snapshot_s = ctrl_wr_s & up_wdata[CTRL_SNAPSHOT_BIT];
    assign clear_s    = ctrl_wr_s & up_wdata[CTRL_CLEAR_BIT];
    assign count_en_s = ~freeze_q;

    // Per-channel counters share snapshot/clear/freeze strobes
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        up_tpl_pn_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk         (up_clk),
            .rst_n       (up_rstn),
            .pn_err      (up_pn_err[g]),
            .count_en    (count_en_s),
`ifdef UP_TPL_PN_STATS_OOS_GATE_EN
            .pn_oos      (up_pn_oos[g]),
            .pn_oos_live (oos_live_q[g]),
`endif
            .clear       (clear_s),
            .snapshot    (snapshot_s),
            .shadow      (shadow_s[g]),
            .ovf_set     (ovf_set_s[g])
        );
    end

    // Register writes, OOS edge detect, sticky set-beats-clear, irq combine
    always_comb begin
        freeze_d   = freeze_q;
        irq_mask_d = irq_mask_q;
        oos_w1c_s  = '0;
        ovf_w1c_s  = '0;
        if (w_hit_s) begin
            case (w_off_s)
                REG_CONTROL:    freeze_d   = up_wdata[CTRL_FREEZE_BIT];
                REG_OOS_STICKY: oos_w1c_s  = up_wdata[NUM_CHANNELS-1:0];
                REG_OVF_STICKY: ovf_w1c_s  = up_wdata[NUM_CHANNELS-1:0];
                REG_IRQ_MASK:   irq_mask_d = up_wdata & IRQ_MASK_WR;
                default:        freeze_d   = freeze_q;
            endcase
        end else begin
            freeze_d = freeze_q;
        end

        oos_live_d   = up_pn_oos;
        oos_prev_d   = oos_live_q;
        oos_edge_s   = oos_live_q & ~oos_prev_q;
        oos_sticky_d = (oos_sticky_q & ~oos_w1c_s) | oos_edge_s;
        ovf_sticky_d = (ovf_sticky_q & ~ovf_w1c_s) | ovf_set_s;
        irq_d        = (|(oos_sticky_q & irq_mask_q[NUM_CHANNELS-1:0])) |
                       ((|ovf_sticky_q) & irq_mask_q[31]);
    end

    // Read mux: fixed registers below 0x20, shadow counts from 0x20 upward
    always_comb begin
        rd_data_s = 32'h0;
        if (is_shadow_offset(r_off_s)) begin
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                if (r_off_s[4:0] == 5'(n)) begin
                    rd_data_s[CNT_WIDTH-1:0] = shadow_s[n];
                end else begin
                    rd_data_s = rd_data_s;
                end
            end
        end else begin
            case (r_off_s)
                REG_CAPS:       rd_data_s = {8'(NUM_CHANNELS), 8'(CNT_WIDTH), CAPS_VERSION};
                REG_CONTROL:    rd_data_s = {29'h0, freeze_q, 2'b00};
                REG_OOS_LIVE:   rd_data_s[NUM_CHANNELS-1:0] = oos_live_q;
                REG_OOS_STICKY: rd_data_s[NUM_CHANNELS-1:0] = oos_sticky_q;
                REG_OVF_STICKY: rd_data_s[NUM_CHANNELS-1:0] = ovf_sticky_q;
                REG_IRQ_MASK:   rd_data_s = irq_mask_q;
                default:        rd_data_s = 32'h0;
            endcase
        end

        wack_d  = w_hit_s;
        rack_d  = r_hit_s;
        rdata_d = r_hit_s ? rd_data_s : 32'h0;
    end

    // Control, status and bus response registers
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            freeze_q     <= 1'b0;
            irq_mask_q   <= 32'h0;
            oos_live_q   <= '0;
            oos_prev_q   <= '0;
            oos_sticky_q <= '0;
            ovf_sticky_q <= '0;
            irq_q        <= 1'b0;
            wack_q       <= 1'b0;
            rack_q       <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            freeze_q     <= freeze_d;
            irq_mask_q   <= irq_mask_d;
            oos_live_q   <= oos_live_d;
            oos_prev_q   <= oos_prev_d;
            oos_sticky_q <= oos_sticky_d;
            ovf_sticky_q <= ovf_sticky_d;
            irq_q        <= irq_d;
            wack_q       <= wack_d;
            rack_q       <= rack_d;
            rdata_q      <= rdata_d;
        end
    end

    assign up_wack   = wack_q;
    assign up_rack   = rack_q;
    assign up_rdata  = rdata_q;
    assign up_pn_irq = irq_q;

endmodule

// File: tb/tb_up_tpl_adc_pn_stats.sv
// Scoreboard bench for up_tpl_adc_pn_stats. Two instances share the bus like
// a parent regmap (OR-combined responses): A at base 0x03 with 8-bit counters,
// B at base 0x04 with 24-bit counters. Expected read data and wack timing are
// queued when a request is issued; a monitor on the falling edge pops them.
module tb_up_tpl_adc_pn_stats;

    localparam int NCH = 4;

    logic            up_clk  = 1'b0;
    logic            up_rstn = 1'b0;
    logic [NCH-1:0]  up_pn_err = '0;
    logic [NCH-1:0]  up_pn_oos = '0;
    logic            up_wreq  = 1'b0;
    logic [13:0]     up_waddr = 14'h0;
    logic [31:0]     up_wdata = 32'h0;
    logic            up_rreq  = 1'b0;
    logic [13:0]     up_raddr = 14'h0;

    logic            wack_a, wack_b, rack_a, rack_b, irq_a, irq_b;
    logic [31:0]     rdata_a, rdata_b;
    logic            wack, rack;
    logic [31:0]     rdata;

    assign wack  = wack_a | wack_b;
    assign rack  = rack_a | rack_b;
    assign rdata = rdata_a | rdata_b;

    up_tpl_adc_pn_stats #(.ADDR_BASE(8'h03), .NUM_CHANNELS(NCH), .CNT_WIDTH(8)) u_dut_a (
        .up_clk(up_clk), .up_rstn(up_rstn), .up_pn_err(up_pn_err), .up_pn_oos(up_pn_oos),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(wack_a),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(rdata_a), .up_rack(rack_a),
        .up_pn_irq(irq_a));

    up_tpl_adc_pn_stats #(.ADDR_BASE(8'h04), .NUM_CHANNELS(NCH), .CNT_WIDTH(24)) u_dut_b (
        .up_clk(up_clk), .up_rstn(up_rstn), .up_pn_err(up_pn_err), .up_pn_oos(up_pn_oos),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(wack_b),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(rdata_b), .up_rack(rack_b),
        .up_pn_irq(irq_b));

    always #5 up_clk = ~up_clk;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } rexp_t;

    rexp_t rq[$];
    int    wq[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    rexp_t e;

    // Cycle counter advanced on every rising edge
    initial forever begin
        @(posedge up_clk);
        cyc++;
    end

    // Monitor: compare every read/write acknowledge against the queues
    initial forever begin
        @(negedge up_clk);
        if (rack) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rack rdata=%h", rdata);
            end else begin
                e = rq.pop_front();
                if (rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s rdata=%h exp=%h cycle=%0d due=%0d", e.name, rdata, e.data, cyc, e.due);
                end
            end
        end else begin
            checks++;
            if (rdata !== 32'h0) begin
                errors++;
                $display("FAIL idle_rdata rdata=%h exp=00000000", rdata);
            end
            while (rq.size() > 0 && rq[0].due < cyc) begin
                e = rq.pop_front();
                checks++;
                errors++;
                $display("FAIL %s no_rack due=%0d now=%0d", e.name, e.due, cyc);
            end
        end
        if (wack) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wack cycle=%0d", cyc);
            end else if (wq.pop_front() != cyc) begin
                errors++;
                $display("FAIL wack_latency cycle=%0d", cyc);
            end
        end else begin
            while (wq.size() > 0 && wq[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL no_wack due=%0d now=%0d", wq.pop_front(), cyc);
            end
        end
    end

    function automatic logic [13:0] ra(input logic [5:0] off);
        return {8'h03, off};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic rd_issue(input logic [13:0] a, input logic [31:0] exp, input string nm);
        up_rreq  = 1'b1;
        up_raddr = a;
        rq.push_back('{data: exp, due: cyc + 1, name: nm});
    endtask

    task automatic wr_issue(input logic [13:0] a, input logic [31:0] d);
        up_wreq  = 1'b1;
        up_waddr = a;
        up_wdata = d;
        wq.push_back(cyc + 1);
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string nm);
        @(negedge up_clk);
        rd_issue(a, exp, nm);
        @(negedge up_clk);
        up_rreq = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge up_clk);
        wr_issue(a, d);
        @(negedge up_clk);
        up_wreq = 1'b0;
    endtask

    task automatic run_err(input int ch, input int k);
        @(negedge up_clk);
        up_pn_err[ch] = 1'b1;
        repeat (k) @(negedge up_clk);
        up_pn_err[ch] = 1'b0;
    endtask

    // Bounded run time
    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge up_clk);
        chk("reset_rack", {31'h0, rack}, 32'h0);
        chk("reset_wack", {31'h0, wack}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", {30'h0, irq_a, irq_b}, 32'h0);
        up_rstn = 1'b1;

        // CAPS of both instances, a miss, unused offsets
        rd({8'h03, 6'h00}, 32'h0408_0001, "caps_a");
        rd({8'h04, 6'h00}, 32'h0418_0001, "caps_b");
        @(negedge up_clk);
        up_rreq = 1'b1; up_raddr = {8'h05, 6'h00};
        @(negedge up_clk);
        up_rreq = 1'b0;
        chk("miss_rack", {31'h0, rack}, 32'h0);
        chk("miss_rdata", rdata, 32'h0);
        rd(ra(6'h10), 32'h0, "unused_off");
        rd(ra(6'h24), 32'h0, "shadow_oob");
        wr(ra(6'h10), 32'hFFFF_FFFF);

        // Counting and snapshot on channel 2
        run_err(2, 37);
        wr(ra(6'h01), 32'h1);
        rd(ra(6'h22), 32'd37, "shadow2_37");
        rd(ra(6'h20), 32'd0, "shadow0_zero");
        run_err(2, 5);
        rd(ra(6'h22), 32'd37, "shadow2_held");
        wr(ra(6'h01), 32'h1);
        rd(ra(6'h22), 32'd42, "shadow2_42");
        rd(ra(6'h01), 32'h0, "control_selfclr");

        // Read of a shadow in the snapshot cycle returns the old shadow
        run_err(1, 6);
        wr(ra(6'h01), 32'h1);
        run_err(1, 2);
        @(negedge up_clk);
        wr_issue(ra(6'h01), 32'h1);
        rd_issue(ra(6'h21), 32'd6, "shadow1_old");
        @(negedge up_clk);
        up_wreq = 1'b0; up_rreq = 1'b0;
        rd(ra(6'h21), 32'd8, "shadow1_new");

        // FREEZE holds the counters
        wr(ra(6'h01), 32'h4);
        rd(ra(6'h01), 32'h4, "control_freeze");
        run_err(3, 5);
        wr(ra(6'h01), 32'h5);
        rd(ra(6'h23), 32'd0, "shadow3_frozen");
        wr(ra(6'h01), 32'h0);

        // Saturation and overflow sticky on channel 0
        wr(ra(6'h01), 32'h2);
        run_err(0, 300);
        wr(ra(6'h01), 32'h1);
        rd(ra(6'h20), 32'd255, "shadow0_sat");
        rd(ra(6'h04), 32'h1, "ovf_set");
        wr(ra(6'h04), 32'h1);
        rd(ra(6'h04), 32'h0, "ovf_w1c");
        wr(ra(6'h01), 32'h1);
        rd(ra(6'h20), 32'd255, "shadow0_still_sat");

        // IRQ_MASK writable bits
        wr(ra(6'h05), 32'hFFFF_FFFF);
        rd(ra(6'h05), 32'h8000_000F, "irq_mask_bits");

        // OOS_LIVE and sticky
        @(negedge up_clk);
        up_pn_oos[3] = 1'b1;
        rd(ra(6'h02), 32'h8, "oos_live");
        up_pn_oos[3] = 1'b0;
        repeat (3) @(negedge up_clk);
        wr(ra(6'h03), 32'hF);
        wr(ra(6'h05), 32'h2);
        @(negedge up_clk);
        up_pn_oos[1] = 1'b1;
        repeat (3) @(negedge up_clk);
        up_pn_oos[1] = 1'b0;
        repeat (3) @(negedge up_clk);
        rd(ra(6'h03), 32'h2, "oos_sticky");
        chk("irq_oos", {31'h0, irq_a}, 32'h1);
        // W1C in the same cycle as a new edge: set wins
        @(negedge up_clk);
        up_pn_oos[1] = 1'b1;
        @(negedge up_clk);
        wr_issue(ra(6'h03), 32'h2);
        @(negedge up_clk);
        up_wreq = 1'b0;
        up_pn_oos[1] = 1'b0;
        rd(ra(6'h03), 32'h2, "oos_set_wins");
        wr(ra(6'h03), 32'h2);
        rd(ra(6'h03), 32'h0, "oos_w1c");
        repeat (2) @(negedge up_clk);
        chk("irq_cleared", {31'h0, irq_a}, 32'h0);

        // SNAPSHOT+CLEAR in one write while channel 0 is counting
        wr(ra(6'h01), 32'h2);
        @(negedge up_clk);
        up_pn_err[0] = 1'b1;
        repeat (10) @(negedge up_clk);
        wr_issue(ra(6'h01), 32'h3);
        @(negedge up_clk);
        up_wreq = 1'b0;
        repeat (2) @(negedge up_clk);
        up_pn_err[0] = 1'b0;
        rd(ra(6'h20), 32'd10, "snap_clear_shadow");
        wr(ra(6'h01), 32'h1);
        rd(ra(6'h20), 32'd2, "snap_clear_restart");

        // OOS gating: err high 40 cycles, OOS high for the first 10
        wr(ra(6'h01), 32'h2);
        @(negedge up_clk);
        up_pn_err[0] = 1'b1;
        up_pn_oos[0] = 1'b1;
        repeat (10) @(negedge up_clk);
        up_pn_oos[0] = 1'b0;
        repeat (30) @(negedge up_clk);
        up_pn_err[0] = 1'b0;
        wr(ra(6'h01), 32'h1);
`ifdef UP_TPL_PN_STATS_OOS_GATE_EN
        rd(ra(6'h20), 32'd14, "oos_gate");
`else
        rd(ra(6'h20), 32'd40, "oos_nogate");
`endif

        // Asynchronous reset mid-count with irq raised
        wr(ra(6'h05), 32'h1);
        repeat (3) @(negedge up_clk);
        chk("irq_before_reset", {31'h0, irq_a}, 32'h1);
        up_pn_err[0] = 1'b1;
        repeat (3) @(posedge up_clk);
        #2 up_rstn = 1'b0;
        #1;
        chk("rst_irq", {31'h0, irq_a}, 32'h0);
        chk("rst_bus", {rdata[29:0], rack, wack}, 32'h0);
        @(negedge up_clk);
        up_pn_err[0] = 1'b0;
        up_rstn = 1'b1;
        wr(ra(6'h01), 32'h1);
        rd(ra(6'h20), 32'd0, "rst_shadow0");
        rd(ra(6'h05), 32'h0, "rst_mask");
        rd(ra(6'h03), 32'h0, "rst_oos_sticky");

        repeat (4) @(negedge up_clk);
        chk("rq_drained", rq.size(), 32'h0);
        chk("wq_drained", wq.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
